tiny_rv_decode: RTL

- Decode stage directly downstream of the instruction fetch stage.
- Consumes the fetched PC/instruction pair and decodes the RV32I instruction.
- Reads the internal 32x32 register file, with a write-back bypass.
- Registers the decoded fields for execute.
- Detects load-use hazards, inserts a bubble, and stalls fetch.

---
 rtl/tiny_rv_decode.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/tiny_rv_decode.sv
// tiny_rv_decode -- RV32I decode stage sitting directly behind instruction fetch.
//
// Decodes the fetched instruction, reads the 31-entry register file (with a
// write-back bypass), and registers the decoded bundle for execute with one
// cycle of latency. A load immediately followed by a consumer of its result
// is split by a bubble while fetch is held for one cycle.
//
// Ports:
//   i_clk, i_reset        clock and synchronous active-high reset
//   i_fetched_pc/inst     PC/instruction pair from fetch (inst 0 = bubble)
//   i_pipe_stall          hold every registered output
//   i_pipe_flush          load a bubble
//   i_wb_en/rd/data       register-file write port
//   o_load_use_stall      combinational request for fetch to hold
//   o_valid .. o_illegal  registered decoded instruction for execute
module tiny_rv_decode #(
   parameter int XLEN          = 32,
   parameter bit RF_RESET_ZERO = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_reset,
   input  logic [XLEN-1:0] i_fetched_pc,
   input  logic [XLEN-1:0] i_fetched_inst,
   input  logic            i_pipe_stall,
   input  logic            i_pipe_flush,
   input  logic            i_wb_en,
   input  logic [4:0]      i_wb_rd,
   input  logic [XLEN-1:0] i_wb_data,
   output logic            o_load_use_stall,
   output logic            o_valid,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_rs1_data,
   output logic [XLEN-1:0] o_rs2_data,
   output logic [XLEN-1:0] o_imm,
   output logic [4:0]      o_rd,
   output logic [3:0]      o_alu_op,
   output logic            o_is_load,
   output logic            o_is_store,
   output logic            o_is_branch,
   output logic            o_is_jal,
   output logic            o_is_jalr,
   output logic            o_is_lui,
   output logic            o_is_auipc,
   output logic            o_illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rd;
      logic [3:0]      alu_op;
      logic            is_load;
      logic            is_store;
      logic            is_branch;
      logic            is_jal;
      logic            is_jalr;
      logic            is_lui;
      logic            is_auipc;
      logic            illegal;
   } dec_t;

   dec_t out_q, out_d, cap_d;

   // ---------------------------------------------------------------- fields
   logic [XLEN-1:0] inst;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [4:0]      rs1_idx, rs2_idx, rd_idx;
   logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign inst    = i_fetched_inst;
   assign opcode  = inst[6:0];
   assign funct3  = inst[14:12];
   assign rs1_idx = inst[19:15];
   assign rs2_idx = inst[24:20];
   assign rd_idx  = inst[11:7];

   assign imm_i = {{20{inst[31]}}, inst[31:20]};
   assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u = {inst[31:12], 12'b0};
   assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   // ---------------------------------------------------------- register file
   // x0 has no storage; reads of index 0 are forced to zero below.
   logic [XLEN-1:0] rf_q [1:31];

   generate
      for (genvar gi = 1; gi < 32; gi++) begin : g_rf
         always_ff @(posedge i_clk) begin
            if (i_reset && RF_RESET_ZERO) begin
               rf_q[gi] <= '0;
            end else if (i_wb_en && (i_wb_rd == 5'(gi))) begin
               rf_q[gi] <= i_wb_data;
            end
         end
      end
   endgenerate

   logic [XLEN-1:0] rs1_rf, rs2_rf;

   // Same-edge write-back is forwarded so the captured operand is never stale.
   always_comb begin
      rs1_rf = '0;
      rs2_rf = '0;
      if (rs1_idx != 5'd0) begin
         rs1_rf = (i_wb_en && i_wb_rd == rs1_idx) ? i_wb_data : rf_q[rs1_idx];
      end
      if (rs2_idx != 5'd0) begin
         rs2_rf = (i_wb_en && i_wb_rd == rs2_idx) ? i_wb_data : rf_q[rs2_idx];
      end
   end

   // ---------------------------------------------------------------- decode
   logic rs1_used, rs2_used;

   always_comb begin
      cap_d    = '0;
      rs1_used = 1'b0;
      rs2_used = 1'b0;
      if (inst != '0) begin
         cap_d.valid = 1'b1;
         cap_d.pc    = i_fetched_pc;
         unique case (opcode)
            OPC_LUI: begin
               cap_d.is_lui = 1'b1;
               cap_d.imm    = imm_u;
               cap_d.rd     = rd_idx;
            end
            OPC_AUIPC: begin
               cap_d.is_auipc = 1'b1;
               cap_d.imm      = imm_u;
               cap_d.rd       = rd_idx;
            end
            OPC_JAL: begin
               cap_d.is_jal = 1'b1;
               cap_d.imm    = imm_j;
               cap_d.rd     = rd_idx;
            end
            OPC_JALR: begin
               cap_d.is_jalr = 1'b1;
               cap_d.imm     = imm_i;
               cap_d.rd      = rd_idx;
               rs1_used      = 1'b1;
            end
            OPC_BRANCH: begin
               cap_d.is_branch = 1'b1;
               cap_d.imm       = imm_b;
               cap_d.alu_op    = {1'b0, funct3};
               rs1_used        = 1'b1;
               rs2_used        = 1'b1;
            end
            OPC_LOAD: begin
               cap_d.is_load = 1'b1;
               cap_d.imm     = imm_i;
               cap_d.rd      = rd_idx;
               rs1_used      = 1'b1;
            end
            OPC_STORE: begin
               cap_d.is_store = 1'b1;
               cap_d.imm      = imm_s;
               rs1_used       = 1'b1;
               rs2_used       = 1'b1;
            end
            OPC_OPIMM: begin
               // Only the shift-right group uses inst[30] as an op selector;
               // elsewhere it is just an immediate bit.
               cap_d.imm    = imm_i;
               cap_d.rd     = rd_idx;
               cap_d.alu_op = {(funct3 == 3'b101) ? inst[30] : 1'b0, funct3};
               rs1_used     = 1'b1;
            end
            OPC_OP: begin
               cap_d.rd     = rd_idx;
               cap_d.alu_op = {inst[30], funct3};
               rs1_used     = 1'b1;
               rs2_used     = 1'b1;
            end
            OPC_FENCE: begin
               // Valid no-op: nothing beyond valid/pc.
            end
            default: begin
               cap_d.illegal = 1'b1;
            end
         endcase
         cap_d.rs1_data = rs1_used ? rs1_rf : '0;
         cap_d.rs2_data = rs2_used ? rs2_rf : '0;
      end
   end

   // ------------------------------------------------------------- load-use
   logic hazard;

   // Once the bubble is in place o_is_load drops, so this lasts one cycle.
   assign hazard = out_q.valid && out_q.is_load && (out_q.rd != 5'd0) &&
                   ((rs1_used && rs1_idx == out_q.rd) ||
                    (rs2_used && rs2_idx == out_q.rd));

   assign o_load_use_stall = hazard && !i_pipe_stall && !i_pipe_flush && !i_reset;

   // ------------------------------------------------------ output register
   always_comb begin
      out_d = out_q;
      if (i_pipe_flush) begin
         out_d = '0;
      end else if (i_pipe_stall) begin
         out_d = out_q;
      end else if (hazard) begin
         out_d = '0;
      end else begin
         out_d = cap_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         out_q <= '0;
      end else begin
         out_q <= out_d;
      end
   end

   assign o_valid     = out_q.valid;
   assign o_pc        = out_q.pc;
   assign o_rs1_data  = out_q.rs1_data;
   assign o_rs2_data  = out_q.rs2_data;
   assign o_imm       = out_q.imm;
   assign o_rd        = out_q.rd;
   assign o_alu_op    = out_q.alu_op;
   assign o_is_load   = out_q.is_load;
   assign o_is_store  = out_q.is_store;
   assign o_is_branch = out_q.is_branch;
   assign o_is_jal    = out_q.is_jal;
   assign o_is_jalr   = out_q.is_jalr;
   assign o_is_lui    = out_q.is_lui;
   assign o_is_auipc  = out_q.is_auipc;
   assign o_illegal   = out_q.illegal;

endmodule
